pll_lock_sequencer: RTL and testbench

Power-up and lock-supervision controller for the iCE40 PLL that turns the 12 MHz board oscillator into the 48 MHz capture clock.
- Runs on the raw oscillator clock and drives the PLL RESETB pin.
- Synchronises and qualifies the PLL LOCK output, retries the PLL if lock never arrives, and holds the capture/SUMP core in reset until lock has been stable.
- Any lock loss returns the core to reset and re-sequences the PLL.

---
 rtl/pll_seq_pkg.sv | 31 +++
 rtl/sync_2ff.sv | 39 +++
 rtl/pll_lock_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// -----------------------------------------------------------------------------
// pll_seq_pkg
//   Shared types and helpers for the PLL lock sequencer.
//   - pll_state_e : sequencer state encoding (2 bits)
//   - cnt_width() : width of the single shared cycle counter, sized from the
//                   largest of the three cycle-count parameters
// -----------------------------------------------------------------------------
package pll_seq_pkg;

   typedef enum logic [1:0] {
      PLL_RST   = 2'b00,
      WAIT_LOCK = 2'b01,
      STABILIZE = 2'b10,
      RUN       = 2'b11
   } pll_state_e;

   // The counter only ever needs to reach (cycles - 1), so $clog2 of the
   // largest cycle count is enough. Clamp to 1 bit so a degenerate
   // configuration still yields a legal vector.
   function automatic int unsigned cnt_width(input int unsigned reset_cycles,
                                             input int unsigned timeout_cycles,
                                             input int unsigned stable_cycles);
      int unsigned max_cycles;
      max_cycles = reset_cycles;
      if (timeout_cycles > max_cycles) max_cycles = timeout_cycles;
      if (stable_cycles  > max_cycles) max_cycles = stable_cycles;
      if (max_cycles < 2) return 1;
      return $clog2(max_cycles);
   endfunction

endpackage : pll_seq_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Generic two-flop synchroniser for signals arriving asynchronously to i_clk.
//   Both flops reset asynchronously to 0. Only single-bit signals (or bits
//   that are independent of one another) may be passed through it.
//
// Ports
//   i_clk    destination clock
//   i_rst    asynchronous active-high reset
//   i_async  [WIDTH-1:0] asynchronous input
//   o_sync   [WIDTH-1:0] synchronised output, two i_clk edges behind i_async
// -----------------------------------------------------------------------------
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   // NOTE: sequential state uses non-blocking assignments so that r_sync
   // picks up the previous r_meta, giving a true two-stage pipeline.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule : sync_2ff

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//   Power-up and lock supervision for the iCE40 PLL (12 MHz -> 48 MHz).
//   Holds the PLL in reset for a fixed time, waits for a synchronised LOCK,
//   requires LOCK to stay high for a qualification window before releasing
//   the capture core, and re-sequences the PLL on lock loss or on timeout.
//
// Ports
//   clock        12 MHz oscillator clock (the only clock of the block)
//   reset        asynchronous active-high reset
//   locked       raw PLL LOCK, asynchronous to clock
//   restart      one-cycle request to re-sequence the PLL from any state
//   pll_resetb   PLL RESETB pin; 0 holds the PLL in reset
//   core_reset   active-high reset for the capture core
//   ready        1 only while running with a qualified lock
//   lock_lost    sticky flag: lock dropped while running
//   retry_count  [RETRY_WIDTH-1:0] saturating count of lock timeouts
// -----------------------------------------------------------------------------
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned PLL_RESET_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 12000,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1200,
   parameter int unsigned RETRY_WIDTH         = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   locked,
   input  logic                   restart,
   output logic                   pll_resetb,
   output logic                   core_reset,
   output logic                   ready,
   output logic                   lock_lost,
   output logic [RETRY_WIDTH-1:0] retry_count
);

   localparam int unsigned CNT_W =
      cnt_width(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

   // Terminal counts: each phase ends on the cycle the counter reaches N-1.
   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

   // Reject configurations that cannot work at elaboration time.
   if (PLL_RESET_CYCLES < 2) begin : g_bad_reset_cycles
      $error("PLL_RESET_CYCLES must be at least 2");
   end
   if (LOCK_TIMEOUT_CYCLES < 1 || LOCK_STABLE_CYCLES < 1) begin : g_bad_cycles
      $error("LOCK_TIMEOUT_CYCLES and LOCK_STABLE_CYCLES must be non-zero");
   end
   if (RETRY_WIDTH < 1) begin : g_bad_retry_width
      $error("RETRY_WIDTH must be at least 1");
   end

   // --------------------------------------------------------------------------
   // Lock synchroniser
   // --------------------------------------------------------------------------
   logic w_lock_s;

   sync_2ff #(
      .WIDTH (1)
   ) u_lock_sync (
      .i_clk   (clock),
      .i_rst   (reset),
      .i_async (locked),
      .o_sync  (w_lock_s)
   );

   // --------------------------------------------------------------------------
   // State, counter and status registers
   // --------------------------------------------------------------------------
   pll_state_e             r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [RETRY_WIDTH-1:0] r_retry_count;
   logic                   r_lock_lost;
   logic                   r_pll_resetb;
   logic                   r_core_reset;
   logic                   r_ready;

   pll_state_e             w_next_state;
   logic [CNT_W-1:0]       w_next_cnt;
   logic [RETRY_WIDTH-1:0] w_next_retry;
   logic                   w_next_lock_lost;
   logic                   w_cnt_inc;
   logic                   w_retry_inc;
   logic                   w_lock_lost_set;

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first; a path that left
   // one unassigned would infer a latch.
   always_comb begin
      w_next_state    = r_state;
      w_cnt_inc       = 1'b0;
      w_retry_inc     = 1'b0;
      w_lock_lost_set = 1'b0;

      case (r_state)
         PLL_RST: begin
            if (r_cnt == RST_LAST) w_next_state = WAIT_LOCK;
            else                   w_cnt_inc    = 1'b1;
         end

         WAIT_LOCK: begin
            if (w_lock_s) begin
               w_next_state = STABILIZE;
            end else if (r_cnt == TIMEOUT_LAST) begin
               w_next_state = PLL_RST;
               w_retry_inc  = 1'b1;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end

         STABILIZE: begin
            // A drop here is a glitch, not a timeout: re-enter WAIT_LOCK with
            // a fresh timeout window and leave retry_count alone.
            if (!w_lock_s)                  w_next_state = WAIT_LOCK;
            else if (r_cnt == STABLE_LAST)  w_next_state = RUN;
            else                            w_cnt_inc    = 1'b1;
         end

         RUN: begin
            if (!w_lock_s) begin
               w_next_state    = PLL_RST;
               w_lock_lost_set = 1'b1;
            end
         end

         default: w_next_state = PLL_RST;
      endcase

      // restart overrides everything decided above, and the events it
      // pre-empts (timeout, lock loss) are dropped rather than recorded.
      if (restart) begin
         w_next_state    = PLL_RST;
         w_cnt_inc       = 1'b0;
         w_retry_inc     = 1'b0;
         w_lock_lost_set = 1'b0;
      end
   end

   // Counter and status next values.
   always_comb begin
      w_next_cnt       = r_cnt;
      w_next_retry     = r_retry_count;
      w_next_lock_lost = r_lock_lost;

      // Single counter shared by all phases, cleared on any state change.
      if (restart || (w_next_state != r_state)) w_next_cnt = '0;
      else if (w_cnt_inc)                       w_next_cnt = r_cnt + CNT_W'(1);

      if (restart)
         w_next_retry = '0;
      else if (w_retry_inc && (r_retry_count != '1))
         w_next_retry = r_retry_count + RETRY_WIDTH'(1);

      if (restart)              w_next_lock_lost = 1'b0;
      else if (w_lock_lost_set) w_next_lock_lost = 1'b1;
   end

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   // Outputs are registered decodes of the next state, so they track the
   // state register exactly and are glitch-free flop outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= PLL_RST;
         r_cnt         <= '0;
         r_retry_count <= '0;
         r_lock_lost   <= 1'b0;
         r_pll_resetb  <= 1'b0;
         r_core_reset  <= 1'b1;
         r_ready       <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_cnt         <= w_next_cnt;
         r_retry_count <= w_next_retry;
         r_lock_lost   <= w_next_lock_lost;
         r_pll_resetb  <= (w_next_state != PLL_RST);
         r_core_reset  <= (w_next_state != RUN);
         r_ready       <= (w_next_state == RUN);
      end
   end

   assign pll_resetb  = r_pll_resetb;
   assign core_reset  = r_core_reset;
   assign ready       = r_ready;
   assign lock_lost   = r_lock_lost;
   assign retry_count = r_retry_count;

endmodule : pll_lock_sequencer

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//   Directed bench for pll_lock_sequencer with small cycle parameters
//   (reset 4, timeout 20, stable 8, retry width 2). Expected values are
//   hand-derived edge counts; inputs change and outputs are sampled 1 ns
//   after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

   localparam int unsigned P_RST    = 4;
   localparam int unsigned P_TMO    = 20;
   localparam int unsigned P_STABLE = 8;
   localparam int unsigned P_RW     = 2;

   logic            clock;
   logic            reset;
   logic            locked;
   logic            restart;
   logic            pll_resetb;
   logic            core_reset;
   logic            ready;
   logic            lock_lost;
   logic [P_RW-1:0] retry_count;

   int n_checks = 0;
   int n_fail   = 0;

   pll_lock_sequencer #(
      .PLL_RESET_CYCLES    (P_RST),
      .LOCK_TIMEOUT_CYCLES (P_TMO),
      .LOCK_STABLE_CYCLES  (P_STABLE),
      .RETRY_WIDTH         (P_RW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .locked      (locked),
      .restart     (restart),
      .pll_resetb  (pll_resetb),
      .core_reset  (core_reset),
      .ready       (ready),
      .lock_lost   (lock_lost),
      .retry_count (retry_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Count edges until ready is seen high, bounded by max_ticks.
   task automatic wait_ready(input int max_ticks, output int n);
      n = 0;
      while (!ready && n < max_ticks) begin
         tick();
         n++;
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_pll_resetb"},  32'(pll_resetb),  0);
      check({tag, "_core_reset"},  32'(core_reset),  1);
      check({tag, "_ready"},       32'(ready),       0);
      check({tag, "_lock_lost"},   32'(lock_lost),   0);
      check({tag, "_retry_count"}, 32'(retry_count), 0);
   endtask

   initial begin
      int n;
      bit saw_ready;
      bit saw_pll_rst;
      logic [1:0] retry_exp [4];
      retry_exp[0] = 2'd1;
      retry_exp[1] = 2'd2;
      retry_exp[2] = 2'd3;
      retry_exp[3] = 2'd3;

      reset   = 1'b1;
      locked  = 1'b0;
      restart = 1'b0;

      // ---------------- Power-up ----------------
      #12;
      check_reset_values("rst");
      reset = 1'b0;                       // first edge after this is E1
      repeat (3) tick();                  // E3: still in PLL_RST
      check("pu_resetb_low_e3", 32'(pll_resetb), 0);
      tick();                             // E4: WAIT_LOCK
      check("pu_resetb_high_e4", 32'(pll_resetb), 1);
      repeat (6) tick();                  // E10
      check("pu_core_reset_wait", 32'(core_reset), 1);
      locked = 1'b1;
      wait_ready(40, n);
      check("pu_ready_latency", 32'(n), 11);
      check("pu_core_reset_run", 32'(core_reset), 0);
      check("pu_retry", 32'(retry_count), 0);
      check("pu_lock_lost", 32'(lock_lost), 0);

      // ---------------- Lock loss ----------------
      repeat (3) tick();
      locked = 1'b0;
      repeat (2) tick();                  // D2: lock_s just went low
      check("ll_ready_d2", 32'(ready), 1);
      check("ll_core_reset_d2", 32'(core_reset), 0);
      tick();                             // D3: back to PLL_RST
      check("ll_core_reset_d3", 32'(core_reset), 1);
      check("ll_ready_d3", 32'(ready), 0);
      check("ll_lock_lost_d3", 32'(lock_lost), 1);
      check("ll_resetb_d3", 32'(pll_resetb), 0);
      repeat (3) tick();                  // D6
      check("ll_resetb_d6", 32'(pll_resetb), 0);
      tick();                             // D7: WAIT_LOCK
      check("ll_resetb_d7", 32'(pll_resetb), 1);
      locked = 1'b1;
      wait_ready(40, n);
      check("ll_relock_latency", 32'(n), 11);
      check("ll_lock_lost_sticky", 32'(lock_lost), 1);
      check("ll_retry", 32'(retry_count), 0);

      // ---------------- Timeout / saturation ----------------
      repeat (2) tick();
      locked = 1'b0;
      repeat (3) tick();                  // D3: PLL_RST
      check("to_resetb_d3", 32'(pll_resetb), 0);
      repeat (23) tick();                 // D26: last WAIT_LOCK cycle
      check("to_resetb_d26", 32'(pll_resetb), 1);
      check("to_retry_d26", 32'(retry_count), 0);
      for (int k = 0; k < 4; k++) begin
         tick();                          // timeout edge
         check($sformatf("to_resetb_fall_%0d", k), 32'(pll_resetb), 0);
         check($sformatf("to_retry_%0d", k), 32'(retry_count), 32'(retry_exp[k]));
         repeat (3) tick();
         check($sformatf("to_resetb_low4_%0d", k), 32'(pll_resetb), 0);
         tick();
         check($sformatf("to_resetb_rise_%0d", k), 32'(pll_resetb), 1);
         repeat (19) tick();              // one edge before the next timeout
      end
      check("to_ready_never", 32'(ready), 0);

      // ---------------- Restart colliding with timeout ----------------
      restart = 1'b1;
      tick();
      restart = 1'b0;
      check("rc_resetb", 32'(pll_resetb), 0);
      check("rc_retry_cleared", 32'(retry_count), 0);
      check("rc_lock_lost_cleared", 32'(lock_lost), 0);
      repeat (3) tick();
      check("rc_resetb_low4", 32'(pll_resetb), 0);
      tick();                             // WAIT_LOCK, counter 0
      check("rc_resetb_rise", 32'(pll_resetb), 1);

      // ---------------- Glitch during STABILIZE ----------------
      locked      = 1'b1;
      saw_ready   = 1'b0;
      saw_pll_rst = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (ready)       saw_ready   = 1'b1;
         if (!pll_resetb) saw_pll_rst = 1'b1;
         if (i == 5) locked = 1'b0;
      end
      check("gl_no_ready", 32'(saw_ready), 0);
      check("gl_no_pll_reset", 32'(saw_pll_rst), 0);
      locked = 1'b1;
      wait_ready(40, n);
      check("gl_ready_latency", 32'(n), 11);
      check("gl_retry_unchanged", 32'(retry_count), 0);

      // ---------------- Async reset mid-STABILIZE ----------------
      repeat (2) tick();
      locked = 1'b0;
      repeat (3) tick();                  // D3: lock lost
      check("ar_lock_lost", 32'(lock_lost), 1);
      repeat (24) tick();                 // D27: first timeout
      check("ar_retry_1", 32'(retry_count), 1);
      repeat (4) tick();                  // D31: WAIT_LOCK
      locked = 1'b1;
      repeat (5) tick();                  // S5: STABILIZE, counter 2
      check("ar_pre_resetb", 32'(pll_resetb), 1);
      check("ar_pre_ready", 32'(ready), 0);
      #3 reset = 1'b1;                    // between edges
      #1;
      check_reset_values("ar_async");
      tick();
      check("ar_held_resetb", 32'(pll_resetb), 0);
      reset = 1'b0;                       // next edge is E1
      repeat (3) tick();
      check("ar_rel_resetb_e3", 32'(pll_resetb), 0);
      tick();
      check("ar_rel_resetb_e4", 32'(pll_resetb), 1);
      // Sync flops restart from 0: lock_s high after E2, STABILIZE at E5,
      // RUN at E13, i.e. 9 edges after E4.
      wait_ready(40, n);
      check("ar_ready_latency", 32'(n), 9);
      check("ar_retry_after", 32'(retry_count), 0);
      check("ar_lock_lost_after", 32'(lock_lost), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

endmodule : tb_pll_lock_sequencer
